// File: rtl/nda_scheduler_pkg.sv
// Shared definitions for the NDA scheduler: state encoding, field-width
// derivation and the tag-field extraction shared with the pick actor.
package nda_scheduler_pkg;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_OFFER = 1'b1
    } sched_state_e;

    function automatic int tag_width(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    function automatic int cnt_width(input int width, input int flux);
        return width - tag_width(flux);
    endfunction

    // Tag lives in the top bits of a token/result word, above the count field.
    function automatic int unsigned tag_field(input logic [31:0] data, input int width, input int flux);
        return data >> cnt_width(width, flux);
    endfunction

endpackage

// File: rtl/nda_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_i, wrapping.
module nda_scheduler_rr_arbiter
    import nda_scheduler_pkg::*;
#(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = 1
) (
    input  logic [FLUX-1:0]      req_i,
    input  logic [TAG_WIDTH-1:0] last_i,
    output logic                 valid_o,
    output logic [TAG_WIDTH-1:0] grant_o
);

    logic                 hi_found_s;
    logic                 lo_found_s;
    logic [TAG_WIDTH-1:0] hi_idx_s;
    logic [TAG_WIDTH-1:0] lo_idx_s;

    // Split search: indices above last_i have priority over the wrapped ones.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = {TAG_WIDTH{1'b0}};
        lo_idx_s   = {TAG_WIDTH{1'b0}};
        for (int k = 0; k < FLUX; k++) begin
            if (req_i[k] && (TAG_WIDTH'(k) > last_i) && !hi_found_s) begin
                hi_found_s = 1'b1;
                hi_idx_s   = TAG_WIDTH'(k);
            end else if (req_i[k] && (TAG_WIDTH'(k) <= last_i) && !lo_found_s) begin
                lo_found_s = 1'b1;
                lo_idx_s   = TAG_WIDTH'(k);
            end else begin
                hi_found_s = hi_found_s;
            end
        end
        valid_o = hi_found_s | lo_found_s;
        grant_o = hi_found_s ? hi_idx_s : lo_idx_s;
    end

endmodule

// File: rtl/nda_scheduler.sv
// NDA token scheduler for the pick/accumulate actor: offers one flux token at
// a time round-robin, tracks in-flight accumulations and per-flux budgets.
module nda_scheduler
    import nda_scheduler_pkg::*;
#(
    parameter int  FLUX      = 2,
    parameter int  WIDTH     = 8,
    parameter int  TOKW      = 8,
    localparam int TAG_WIDTH = tag_width(FLUX),
    localparam int CW        = cnt_width(WIDTH, FLUX)
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 cfg_wr,
    input  logic [TAG_WIDTH-1:0] cfg_flux,
    input  logic [CW-1:0]        cfg_cnt,
    input  logic [TOKW-1:0]      cfg_tokens,
    input  logic [FLUX-1:0]      flux_req,
    output logic [FLUX-1:0]      nda_empty,
    input  logic [FLUX-1:0]      nda_read,
    output logic [WIDTH-1:0]     nda_data,
    input  logic                 done_wr,
    input  logic [WIDTH-1:0]     done_data,
    output logic [FLUX-1:0]      busy,
    output logic [FLUX-1:0]      exhausted,
    output logic                 sched_idle,
    output logic                 proto_err
);

    sched_state_e         state_q, state_d;
    logic [TAG_WIDTH-1:0] g_q, g_d;
    logic [TAG_WIDTH-1:0] last_q, last_d;
    logic [CW-1:0]        lcnt_q, lcnt_d;
    logic [FLUX-1:0]      busy_q, busy_d;
    logic [FLUX-1:0]      exh_q, exh_d;
    logic                 perr_q, perr_d;
    logic [CW-1:0]        cnt_q [FLUX];
    logic [CW-1:0]        cnt_d [FLUX];
    logic [TOKW-1:0]      tok_q [FLUX];
    logic [TOKW-1:0]      tok_d [FLUX];

    logic [FLUX-1:0]      elig_s;
    logic [FLUX-1:0]      gmask_s;
    logic                 arb_valid_s;
    logic [TAG_WIDTH-1:0] arb_grant_s;
    logic [TAG_WIDTH-1:0] done_tag_s;
    logic                 read_ok_s;

    // Eligibility from registered state only, plus one-hot of the held grant.
    always_comb begin
        elig_s  = {FLUX{1'b0}};
        gmask_s = {FLUX{1'b0}};
        for (int f = 0; f < FLUX; f++) begin
            elig_s[f]  = (cnt_q[f] != {CW{1'b0}}) & flux_req[f] & ~busy_q[f] & ~exh_q[f];
            gmask_s[f] = (g_q == TAG_WIDTH'(f));
        end
    end

    assign done_tag_s = TAG_WIDTH'(tag_field(32'(done_data), WIDTH, FLUX));
    assign read_ok_s  = (state_q == ST_OFFER) && (nda_read == gmask_s);

    nda_scheduler_rr_arbiter #(
        .FLUX      (FLUX),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_arb (
        .req_i   (elig_s),
        .last_i  (last_q),
        .valid_o (arb_valid_s),
        .grant_o (arb_grant_s)
    );

    // Next-state: arbitration/offer FSM, busy/budget bookkeeping, config writes.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        lcnt_d  = lcnt_q;
        busy_d  = busy_q;
        exh_d   = exh_q;
        cnt_d   = cnt_q;
        tok_d   = tok_q;

        if ((nda_read != {FLUX{1'b0}}) && !read_ok_s) begin
            perr_d = 1'b1;
        end else begin
            perr_d = perr_q;
        end

        if (done_wr) begin
            for (int f = 0; f < FLUX; f++) begin
                if (done_tag_s == TAG_WIDTH'(f)) begin
                    busy_d[f] = 1'b0;
                end else begin
                    busy_d[f] = busy_d[f];
                end
            end
        end else begin
            busy_d = busy_q;
        end

        case (state_q)
            ST_ARB: begin
                if (arb_valid_s) begin
                    state_d = ST_OFFER;
                    g_d     = arb_grant_s;
                    for (int f = 0; f < FLUX; f++) begin
                        if (arb_grant_s == TAG_WIDTH'(f)) begin
                            lcnt_d = cnt_q[f];
                        end else begin
                            lcnt_d = lcnt_d;
                        end
                    end
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_OFFER: begin
                if (read_ok_s) begin
                    state_d = ST_ARB;
                    last_d  = g_q;
                    busy_d  = busy_d | gmask_s;
                    for (int f = 0; f < FLUX; f++) begin
                        if (gmask_s[f] && (tok_q[f] != {TOKW{1'b0}})) begin
                            tok_d[f] = tok_q[f] - TOKW'(1);
                            exh_d[f] = exh_q[f] | (tok_q[f] == TOKW'(1));
                        end else begin
                            tok_d[f] = tok_q[f];
                        end
                    end
                end else begin
                    state_d = ST_OFFER;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        // Config is applied last so it overrides a same-cycle budget decrement.
        if (cfg_wr) begin
            for (int f = 0; f < FLUX; f++) begin
                if (cfg_flux == TAG_WIDTH'(f)) begin
                    cnt_d[f] = cfg_cnt;
                    tok_d[f] = cfg_tokens;
                    exh_d[f] = 1'b0;
                end else begin
                    cnt_d[f] = cnt_d[f];
                end
            end
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State registers; reset withdraws any pending offer and clears config.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ARB;
            g_q     <= {TAG_WIDTH{1'b0}};
            last_q  <= TAG_WIDTH'(FLUX - 1);
            lcnt_q  <= {CW{1'b0}};
            busy_q  <= {FLUX{1'b0}};
            exh_q   <= {FLUX{1'b0}};
            perr_q  <= 1'b0;
            for (int f = 0; f < FLUX; f++) begin
                cnt_q[f] <= {CW{1'b0}};
                tok_q[f] <= {TOKW{1'b0}};
            end
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            lcnt_q  <= lcnt_d;
            busy_q  <= busy_d;
            exh_q   <= exh_d;
            perr_q  <= perr_d;
            cnt_q   <= cnt_d;
            tok_q   <= tok_d;
        end
    end

    assign nda_empty  = (state_q == ST_OFFER) ? ~gmask_s : {FLUX{1'b1}};
    assign nda_data   = (state_q == ST_OFFER) ? {g_q, lcnt_q} : {WIDTH{1'b0}};
    assign busy       = busy_q;
    assign exhausted  = exh_q;
    assign proto_err  = perr_q;
    assign sched_idle = (state_q == ST_ARB) && (busy_q == {FLUX{1'b0}});

endmodule

// File: tb/tb_nda_scheduler.sv
// Self-checking bench for nda_scheduler: directed scenarios followed by
// randomized actor traffic, all checked against a behavioural model.
module tb_nda_scheduler;

    localparam int FLUX  = 2;
    localparam int WIDTH = 8;
    localparam int TOKW  = 8;
    localparam int TW    = 1;
    localparam int CW    = WIDTH - TW;

    logic              ck = 1'b0;
    logic              rst;
    logic              cfg_wr;
    logic [TW-1:0]     cfg_flux;
    logic [CW-1:0]     cfg_cnt;
    logic [TOKW-1:0]   cfg_tokens;
    logic [FLUX-1:0]   flux_req;
    logic [FLUX-1:0]   nda_empty;
    logic [FLUX-1:0]   nda_read;
    logic [WIDTH-1:0]  nda_data;
    logic              done_wr;
    logic [WIDTH-1:0]  done_data;
    logic [FLUX-1:0]   busy;
    logic [FLUX-1:0]   exhausted;
    logic              sched_idle;
    logic              proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (spec-level view of the scheduler)
    int            m_cnt [FLUX];
    int            m_tok [FLUX];
    bit [FLUX-1:0] m_busy;
    bit [FLUX-1:0] m_exh;
    bit            m_off;
    int            m_g;
    int            m_lcnt;
    int            m_last;
    bit            m_perr;

    nda_scheduler #(.FLUX(FLUX), .WIDTH(WIDTH), .TOKW(TOKW)) dut (
        .ck         (ck),
        .rst        (rst),
        .cfg_wr     (cfg_wr),
        .cfg_flux   (cfg_flux),
        .cfg_cnt    (cfg_cnt),
        .cfg_tokens (cfg_tokens),
        .flux_req   (flux_req),
        .nda_empty  (nda_empty),
        .nda_read   (nda_read),
        .nda_data   (nda_data),
        .done_wr    (done_wr),
        .done_data  (done_data),
        .busy       (busy),
        .exhausted  (exhausted),
        .sched_idle (sched_idle),
        .proto_err  (proto_err)
    );

    always #5 ck = ~ck;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int f = 0; f < FLUX; f++) begin
            m_cnt[f] = 0;
            m_tok[f] = 0;
        end
        m_busy = '0;
        m_exh  = '0;
        m_off  = 1'b0;
        m_g    = 0;
        m_lcnt = 0;
        m_last = FLUX - 1;
        m_perr = 1'b0;
    endtask

    task automatic model_step();
        bit [FLUX-1:0] nb;
        bit            legal;
        int            t;
        legal = m_off && (nda_read == FLUX'(1 << m_g));
        if (nda_read != '0 && !legal) m_perr = 1'b1;
        nb = m_busy;
        if (done_wr) begin
            t = int'(done_data) >> CW;
            if (t < FLUX) nb[t] = 1'b0;
        end
        if (legal) begin
            nb[m_g] = 1'b1;
            m_last  = m_g;
            m_off   = 1'b0;
            if (m_tok[m_g] != 0) begin
                m_tok[m_g] = m_tok[m_g] - 1;
                if (m_tok[m_g] == 0) m_exh[m_g] = 1'b1;
            end
        end else if (!m_off) begin
            for (int i = 1; i <= FLUX; i++) begin
                int f;
                f = (m_last + i) % FLUX;
                if (m_cnt[f] != 0 && flux_req[f] && !m_busy[f] && !m_exh[f]) begin
                    m_g    = f;
                    m_lcnt = m_cnt[f];
                    m_off  = 1'b1;
                    break;
                end
            end
        end
        if (cfg_wr) begin
            m_cnt[cfg_flux] = cfg_cnt;
            m_tok[cfg_flux] = cfg_tokens;
            m_exh[cfg_flux] = 1'b0;
        end
        m_busy = nb;
    endtask

    task automatic compare_all();
        logic [FLUX-1:0]  e_empty;
        logic [WIDTH-1:0] e_data;
        e_empty = m_off ? ~FLUX'(1 << m_g) : '1;
        e_data  = m_off ? WIDTH'((m_g << CW) | m_lcnt) : '0;
        check_val("nda_empty", nda_empty, e_empty);
        check_val("nda_data", nda_data, e_data);
        check_val("busy", busy, m_busy);
        check_val("exhausted", exhausted, m_exh);
        check_val("sched_idle", sched_idle, !m_off && m_busy == '0);
        check_val("proto_err", proto_err, m_perr);
    endtask

    task automatic tick();
        @(posedge ck);
        model_step();
        @(negedge ck);
        compare_all();
    endtask

    task automatic do_cfg(input int f, input int c, input int t);
        cfg_wr = 1'b1; cfg_flux = TW'(f); cfg_cnt = CW'(c); cfg_tokens = TOKW'(t);
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic read_flux(input int f);
        nda_read = FLUX'(1 << f);
        tick();
        nda_read = '0;
    endtask

    task automatic done_tag(input int f);
        done_wr = 1'b1; done_data = WIDTH'(f << CW);
        tick();
        done_wr = 1'b0;
    endtask

    task automatic wait_offer(input int f);
        logic [FLUX-1:0] want;
        want = ~FLUX'(1 << f);
        for (int i = 0; i < 20 && nda_empty != want; i++) tick();
        if (nda_empty != want) check_val("offer_timeout", nda_empty, want);
    endtask

    // Async reset asserted away from the clock edge and checked immediately.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge ck);
        rst = 1'b1;
    endtask

    initial begin
        bit illegal_ok;
        rst = 1'b0; cfg_wr = 1'b0; cfg_flux = '0; cfg_cnt = '0; cfg_tokens = '0;
        flux_req = '0; nda_read = '0; done_wr = 1'b0; done_data = '0;
        model_reset();
        #1 compare_all();
        @(negedge ck);
        @(negedge ck);
        rst = 1'b1;

        // Basic offer and read
        flux_req = 2'b01;
        do_cfg(0, 3, 0);
        tick();
        check_val("t1_empty", nda_empty, 2'b10);
        check_val("t1_data", nda_data, 8'h03);
        read_flux(0);
        check_val("t1_busy", busy, 2'b01);
        check_val("t1_empty_after", nda_empty, 2'b11);

        // Offered count does not change under a config write
        done_tag(0);
        wait_offer(0);
        do_cfg(0, 5, 0);
        check_val("t4_hold", nda_data, 8'h03);
        read_flux(0);
        done_tag(0);
        wait_offer(0);
        check_val("t4_new", nda_data, 8'h05);

        // Read on the wrong flux is a protocol error with no side effects
        read_flux(1);
        check_val("t5_perr", proto_err, 1'b1);
        check_val("t5_busy", busy, 2'b00);
        check_val("t5_empty", nda_empty, 2'b10);
        tick();
        check_val("t5_sticky", proto_err, 1'b1);
        read_flux(0);

        // Budget exhaustion on flux 1, then config clears it
        flux_req = 2'b11;
        do_cfg(1, 2, 2);
        wait_offer(1);
        read_flux(1);
        done_tag(1);
        wait_offer(1);
        read_flux(1);
        done_tag(1);
        tick(); tick(); tick();
        check_val("t3_exh", exhausted, 2'b10);
        check_val("t3_no_offer", nda_empty, 2'b11);
        do_cfg(1, 2, 0);
        check_val("t3_exh_clr", exhausted, 2'b00);
        wait_offer(1);

        // Reset in the middle of an offer
        async_reset();
        check_val("t6_empty", nda_empty, 2'b11);
        check_val("t6_busy", busy, 2'b00);
        tick(); tick();
        check_val("t6_idle", sched_idle, 1'b1);

        // Randomized actor traffic in several segments
        for (int seg = 0; seg < 4; seg++) begin
            illegal_ok = (seg == 2);
            if (seg != 0) async_reset();
            for (int cyc = 0; cyc < 300; cyc++) begin
                flux_req   = FLUX'($urandom);
                cfg_wr     = ($urandom_range(0, 99) < 5);
                cfg_flux   = TW'($urandom_range(0, FLUX - 1));
                cfg_cnt    = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 127));
                cfg_tokens = TOKW'($urandom_range(0, 3));
                nda_read   = (m_off && $urandom_range(0, 99) < 60) ? FLUX'(1 << m_g) : '0;
                if (illegal_ok && $urandom_range(0, 99) < 3) nda_read = FLUX'($urandom_range(1, 3));
                done_wr = 1'b0;
                if (m_busy != '0 && $urandom_range(0, 99) < 35) begin
                    int t;
                    t = $urandom_range(0, FLUX - 1);
                    if (!m_busy[t]) t = (t + 1) % FLUX;
                    done_wr = 1'b1;
                    done_data = WIDTH'((t << CW) | $urandom_range(0, 127));
                end else if ($urandom_range(0, 99) < 3) begin
                    done_wr = 1'b1;
                    done_data = WIDTH'($urandom);
                end
                tick();
            end
            cfg_wr = 1'b0; nda_read = '0; done_wr = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
